// File: rtl/codec_intf.sv
// ----------------------------------------------------------------------------
// codec_intf
//
// Stereo I2S-style link between the external audio codec and the equalizer
// core. A free-running 10-bit frame counter produces the codec clocks:
//   MCLK = clk/4, SCLK = clk/32, LRCLK = clk/1024 (0 = left, 1 = right).
// Each 1024-clk frame holds 32 SCLK bit slots. Slot 0 carries the LSB of the
// previous frame's right word. Slots 1..16 carry the left word, MSB first.
// Slots 17..31 carry the upper 15 bits of the right word.
//
// Rx: SDout is sampled on every SCLK rise. The left word is parked in a hold
//     register mid-frame. At the start of the next frame both words go to
//     lft_in/rht_in together, and `valid` pulses once while in RUN.
// Tx: {lft_out, rht_out} is loaded into a 32-bit shifter at cnt==0x010. The
//     shifter moves one bit onto SDin at every SCLK fall. SDin is forced low
//     until the startup sequence reaches RUN.
// Startup: INIT holds the codec in reset (RSTn=0) for one frame. WAIT then
//     lets the codec settle for STARTUP_FRAMES frames. RUN forwards samples.
//
// Ports
//   clk      in   system clock (nominally 50 MHz)
//   rst      in   asynchronous active-high reset
//   SDout    in   serial ADC data from the codec
//   lft_out  in   signed left sample from the core, to be transmitted
//   rht_out  in   signed right sample from the core, to be transmitted
//   lft_in   out  signed received left sample, to the core
//   rht_in   out  signed received right sample, to the core
//   valid    out  one-clk strobe marking a new lft_in/rht_in pair
//   MCLK     out  codec master clock
//   SCLK     out  serial bit clock
//   LRCLK    out  word select
//   RSTn     out  codec reset, active low
//   SDin     out  serial DAC data to the codec
// ----------------------------------------------------------------------------
module codec_intf #(
    parameter logic [3:0] STARTUP_FRAMES = 4'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SDout,
    input  logic signed [15:0] lft_out,
    input  logic signed [15:0] rht_out,
    output logic signed [15:0] lft_in,
    output logic signed [15:0] rht_in,
    output logic               valid,
    output logic               MCLK,
    output logic               SCLK,
    output logic               LRCLK,
    output logic               RSTn,
    output logic               SDin
);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_WAIT = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    // Frame positions at which the various events happen. Each event fires on
    // the clock edge that ends the cycle in which cnt holds this value.
    localparam logic [9:0] CNT_RIGHT_DONE = 10'h00F;
    localparam logic [9:0] CNT_TX_LOAD    = 10'h010;
    localparam logic [9:0] CNT_LEFT_DONE  = 10'h20F;
    localparam logic [9:0] CNT_FRAME_END  = 10'h3FF;
    localparam logic [4:0] SLOT_RISE      = 5'h0F;
    localparam logic [4:0] SLOT_FALL      = 5'h1F;

    logic [9:0]  cnt;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        frame_end;
    logic        tx_load;
    logic        left_done;
    logic        right_done;
    logic        running;

    // Only the low 15 bits of the receive shifter are ever read back. The
    // incoming bit is appended to form the full 16-bit word, so bit 15 is not
    // stored.
    logic [14:0] rx_shift;
    logic [15:0] rx_word;
    logic [15:0] lft_hold;
    logic [31:0] tx_shift;

    logic [3:0]  fc;
    logic [3:0]  fc_next;
    state_t      state;
    state_t      state_next;

    assign sclk_rise  = (cnt[4:0] == SLOT_RISE);
    assign sclk_fall  = (cnt[4:0] == SLOT_FALL);
    assign frame_end  = (cnt == CNT_FRAME_END);
    assign tx_load    = (cnt == CNT_TX_LOAD);
    assign left_done  = (cnt == CNT_LEFT_DONE);
    assign right_done = (cnt == CNT_RIGHT_DONE);
    assign running    = (state == ST_RUN);
    assign rx_word    = {rx_shift, SDout};

    // The codec clocks are taken straight from counter flops, so they cannot
    // glitch and keep a fixed phase relationship to each other.
    assign MCLK  = cnt[1];
    assign SCLK  = cnt[4];
    assign LRCLK = cnt[9];

    // Free-running frame counter. Every timing event in the block is decoded
    // from it, and it wraps naturally from 0x3FF to 0x000.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 10'd0;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

    // Receive path. The right LSB arrives in slot 0 of the following frame.
    // Publishing on that same rise means lft_in/rht_in always change together.
    // valid marks the new pair only once the codec has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift <= 15'd0;
            lft_hold <= 16'd0;
            lft_in   <= 16'sd0;
            rht_in   <= 16'sd0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (sclk_rise) begin
                rx_shift <= rx_word[14:0];
                if (left_done) begin
                    lft_hold <= rx_word;
                end
                if (right_done) begin
                    lft_in <= lft_hold;
                    rht_in <= rx_word;
                    valid  <= running;
                end
            end
        end
    end

    // Transmit path. The core samples are captured in the cycle valid is high,
    // so the core has a whole frame to produce the next pair. The shifter runs
    // in every state to keep the slot alignment fixed. Only the pin itself is
    // held low until RUN, so the codec never plays stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= 32'd0;
            SDin     <= 1'b0;
        end else if (tx_load) begin
            tx_shift <= {lft_out, rht_out};
        end else if (sclk_fall) begin
            SDin     <= running ? tx_shift[31] : 1'b0;
            tx_shift <= {tx_shift[30:0], 1'b0};
        end
    end

    // Startup sequencer registers. RSTn is registered rather than decoded from
    // the state, so the codec reset pin is glitch-free. RSTn goes high on the
    // same edge that leaves INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            fc    <= 4'd0;
            RSTn  <= 1'b0;
        end else begin
            state <= state_next;
            fc    <= fc_next;
            RSTn  <= (state_next != ST_INIT);
        end
    end

    // Startup sequencer transitions. The sequencer only moves at frame
    // boundaries. WAIT counts whole frames and enters RUN on the wrap where
    // the count reaches STARTUP_FRAMES.
    always_comb begin
        state_next = state;
        fc_next    = fc;
        if (frame_end) begin
            case (state)
                ST_INIT: begin
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    fc_next = fc + 4'd1;
                    if ((fc + 4'd1) == STARTUP_FRAMES) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_intf.sv
// ----------------------------------------------------------------------------
// tb_codec_intf
//
// Self-checking bench for codec_intf. A codec model drives SDout from a table
// of per-frame 32-bit words {left, right}. The words are random, except for a
// few frames that carry fixed patterns. Expected clocks, strobes and data come
// from the frame timeline, computed directly from the elapsed cycle count
// since reset release.
// ----------------------------------------------------------------------------
module tb_codec_intf;

    localparam logic [3:0] N_START = 4'd4;
    localparam int         N       = 4;
    localparam int         FRAME   = 1024;

    logic               clk;
    logic               rst;
    logic               SDout;
    logic signed [15:0] lft_out;
    logic signed [15:0] rht_out;
    logic signed [15:0] lft_in;
    logic signed [15:0] rht_in;
    logic               valid;
    logic               MCLK;
    logic               SCLK;
    logic               LRCLK;
    logic               RSTn;
    logic               SDin;

    int          total;
    int          bad;
    int          cyc;
    logic [31:0] word [0:63];
    bit          loopback;

    codec_intf #(
        .STARTUP_FRAMES(N_START)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .SDout  (SDout),
        .lft_out(lft_out),
        .rht_out(rht_out),
        .lft_in (lft_in),
        .rht_in (rht_in),
        .valid  (valid),
        .MCLK   (MCLK),
        .SCLK   (SCLK),
        .LRCLK  (LRCLK),
        .RSTn   (RSTn),
        .SDin   (SDin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges seen since reset release. At a negedge, cyc % 1024 is the
    // position inside the current frame, and cyc / 1024 + 1 is the frame number.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Bit the codec places in the slot that contains cycle c.
    function automatic logic codec_bit(input int c);
        int p;
        int f;
        int s;
        p = c % FRAME;
        f = c / FRAME + 1;
        s = p / 32;
        if (s == 0) return word[(f - 1) & 63][0];
        return word[f & 63][32 - s];
    endfunction

    // Pair expected on lft_in/rht_in during cycle c. The pair is updated at
    // frame position 0x010 with the word the codec sent in the previous frame.
    function automatic logic [31:0] exp_pair(input int c);
        int p;
        int f;
        int g;
        p = c % FRAME;
        f = c / FRAME + 1;
        g = (p >= 16) ? f - 1 : f - 2;
        if (g <= 0) return 32'd0;
        return word[g & 63];
    endfunction

    // Codec model: updates SDout at every falling clk edge.
    initial begin
        SDout = 1'b0;
        forever begin
            @(negedge clk);
            SDout = loopback ? SDin : codec_bit(cyc);
        end
    end

    task automatic wait_until(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (cyc != t) begin
            bad++;
            $display("[TB] FAIL wait_until cyc=%0d required %0d", cyc, t);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        loopback = 1'b0;
        lft_out  = 16'hFFFF;
        rht_out  = 16'hFFFF;
        repeat (3) @(negedge clk);
        total++;
        if ({MCLK, SCLK, LRCLK} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_clocks got %b required 000", {MCLK, SCLK, LRCLK});
        end
        total++;
        if (RSTn !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_RSTn got %b required 0", RSTn);
        end
        total++;
        if (SDin !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_SDin got %b required 0", SDin);
        end
        total++;
        if (valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_valid got %b required 0", valid);
        end
        total++;
        if (lft_in !== 16'sd0) begin
            bad++; $display("[TB] FAIL reset_lft_in got %h required 0000", lft_in);
        end
        total++;
        if (rht_in !== 16'sd0) begin
            bad++; $display("[TB] FAIL reset_rht_in got %h required 0000", rht_in);
        end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        int c;
        int f;
        int p;
        int guard;
        int e_clk;
        int e_rstn;
        int e_valid;
        int e_sdin;
        int e_data;
        logic [2:0]  x_clk;
        logic [31:0] x_pair;
        logic        x_valid;
        logic        x_sdin;
        e_clk = 0; e_rstn = 0; e_valid = 0; e_sdin = 0; e_data = 0;
        guard = 0;
        while (cyc < 6 * FRAME && guard < 10000) begin
            c = cyc;
            f = c / FRAME + 1;
            p = c % FRAME;
            x_clk   = {(c % 4) >= 2, (c % 32) >= 16, p >= 512};
            x_valid = (f >= N + 2) && (p == 16);
            x_sdin  = (c >= (N + 1) * FRAME + 32);
            x_pair  = exp_pair(c);
            if ({MCLK, SCLK, LRCLK} !== x_clk) begin
                e_clk++;
                if (e_clk == 1) $display("[TB] first clock deviation at cyc %0d", c);
            end
            if (RSTn !== (c >= FRAME)) e_rstn++;
            if (valid !== x_valid) e_valid++;
            if (SDin !== x_sdin) e_sdin++;
            if ({lft_in, rht_in} !== x_pair) e_data++;
            if (c == 511) begin
                total++;
                if (LRCLK !== 1'b0) begin
                    bad++; $display("[TB] FAIL lrclk_before_512 got %b required 0", LRCLK);
                end
            end
            if (c == 512) begin
                total++;
                if (LRCLK !== 1'b1) begin
                    bad++; $display("[TB] FAIL lrclk_rise_512 got %b required 1", LRCLK);
                end
            end
            if (c == FRAME - 1) begin
                total++;
                if (RSTn !== 1'b0) begin
                    bad++; $display("[TB] FAIL rstn_frame1_end got %b required 0", RSTn);
                end
            end
            if (c == FRAME) begin
                total++;
                if (RSTn !== 1'b1) begin
                    bad++; $display("[TB] FAIL rstn_frame2_start got %b required 1", RSTn);
                end
            end
            if (c == N * FRAME + 16) begin
                total++;
                if (valid !== 1'b0) begin
                    bad++; $display("[TB] FAIL valid_frame5 got %b required 0", valid);
                end
            end
            if (c == (N + 1) * FRAME + 16) begin
                total++;
                if (valid !== 1'b1) begin
                    bad++; $display("[TB] FAIL first_valid_frame6 got %b required 1", valid);
                end
            end
            @(negedge clk);
            guard++;
        end
        total++;
        if (e_clk !== 0) begin
            bad++; $display("[TB] FAIL clock_waveforms got %0d bad cycles required 0", e_clk);
        end
        total++;
        if (e_rstn !== 0) begin
            bad++; $display("[TB] FAIL rstn_timing got %0d bad cycles required 0", e_rstn);
        end
        total++;
        if (e_valid !== 0) begin
            bad++; $display("[TB] FAIL valid_timing got %0d bad cycles required 0", e_valid);
        end
        total++;
        if (e_sdin !== 0) begin
            bad++; $display("[TB] FAIL sdin_startup got %0d bad cycles required 0", e_sdin);
        end
        total++;
        if (e_data !== 0) begin
            bad++; $display("[TB] FAIL rx_data_startup got %0d bad cycles required 0", e_data);
        end
    endtask

    task automatic test_rx();
        wait_until(7 * FRAME + 16);
        total++;
        if ({valid, lft_in, rht_in} !== {1'b1, 16'hA5C3, 16'h3C5A}) begin
            bad++; $display("[TB] FAIL rx_a5c3 got v=%b %h/%h required v=1 a5c3/3c5a", valid, lft_in, rht_in);
        end
        wait_until(7 * FRAME + 17);
        total++;
        if (valid !== 1'b0) begin
            bad++; $display("[TB] FAIL valid_one_clk got %b required 0", valid);
        end
        wait_until(8 * FRAME + 16);
        total++;
        if ({valid, lft_in, rht_in} !== {1'b1, 16'h8000, 16'h7FFF}) begin
            bad++; $display("[TB] FAIL rx_extremes got v=%b %h/%h required v=1 8000/7fff", valid, lft_in, rht_in);
        end
    endtask

    task automatic test_tx(input int frame, input logic [15:0] l, input logic [15:0] r);
        int base;
        logic [31:0] got;
        base = (frame - 1) * FRAME;
        got  = 32'd0;
        wait_until(base + 8);
        lft_out = l;
        rht_out = r;
        wait_until(base + 24);
        lft_out = 16'($urandom);
        rht_out = 16'($urandom);
        for (int k = 0; k < 32; k++) begin
            wait_until(base + 32 * k + 47);
            got[31 - k] = SDin;
        end
        total++;
        if (got !== {l, r}) begin
            bad++; $display("[TB] FAIL tx_frame%0d got %h required %h", frame, got, {l, r});
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 14; f <= 16; f++) begin
            wait_until((f - 1) * FRAME + 16);
            total++;
            if ({valid, lft_in, rht_in} !== {1'b1, word[f - 1]}) begin
                bad++; $display("[TB] FAIL rx_random_f%0d got v=%b %h required v=1 %h", f, valid, {lft_in, rht_in}, word[f - 1]);
            end
            wait_until((f - 1) * FRAME + 17);
            total++;
            if (valid !== 1'b0) begin
                bad++; $display("[TB] FAIL valid_drop_f%0d got %b required 0", f, valid);
            end
        end
    endtask

    task automatic test_loopback();
        wait_until(16 * FRAME);
        loopback = 1'b1;
        lft_out  = 16'h1234;
        rht_out  = 16'hEDCB;
        wait_until(18 * FRAME + 16);
        total++;
        if ({lft_in, rht_in} !== {16'h1234, 16'hEDCB}) begin
            bad++; $display("[TB] FAIL loopback got %h/%h required 1234/edcb", lft_in, rht_in);
        end
    endtask

    task automatic test_reset_midframe();
        wait_until(18 * FRAME + 16'h205);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({MCLK, SCLK, LRCLK, RSTn, SDin, valid} !== 6'b000000) begin
            bad++; $display("[TB] FAIL async_reset_ctrl got %b required 000000", {MCLK, SCLK, LRCLK, RSTn, SDin, valid});
        end
        total++;
        if ({lft_in, rht_in} !== 32'd0) begin
            bad++; $display("[TB] FAIL async_reset_data got %h required 00000000", {lft_in, rht_in});
        end
        test_reset();
        test_startup();
        test_rx();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total    = 0;
        bad      = 0;
        loopback = 1'b0;
        rst      = 1'b1;
        lft_out  = 16'hFFFF;
        rht_out  = 16'hFFFF;
        word[0]  = 32'd0;
        for (int i = 1; i < 64; i++) word[i] = $urandom;
        word[7] = {16'hA5C3, 16'h3C5A};
        word[8] = {16'h8000, 16'h7FFF};
        $display("[TB] codec_intf bench start, STARTUP_FRAMES=%0d", N);
        test_reset();
        test_startup();
        test_rx();
        test_tx(10, 16'h8001, 16'h7FFE);
        test_tx(12, 16'($urandom), 16'($urandom));
        test_back_to_back();
        test_loopback();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
